alarm_clock_sequencer: RTL and testbench
========================================

ALARM_CLOCK_SEQUENCER -- requirements
Module: alarm_clock_sequencer

Interface
REQ-001 SHALL have parameter: PERIOD, 32'h2FAF07F, timer reload value (1 s at 50 MHz, counts PERIOD+1 cycles).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: avm_address  out  3  timer register select.
REQ-005 SHALL have ports: avm_chipselect  out  1, avm_write_n  out  1 (active low), avm_writedata  out  16.
REQ-006 SHALL have ports: timer_irq  in  1  level interrupt from interval timer.
REQ-007 SHALL have ports: set_valid  in  1, set_hh  in  5, set_mm  in  6, set_ss  in  6  time-of-day load.
REQ-008 SHALL have ports: alarm_valid  in  1, alarm_hh  in  5, alarm_mm  in  6  alarm time load.
REQ-009 SHALL have ports: alarm_en  in  1  alarm arm; alarm_stop  in  1  pulse, silence alarm.
REQ-010 SHALL have ports: hh  out  5, mm  out  6, ss  out  6  binary time of day; sec_tick  out  1  one-cycle pulse per second; alarm_ring  out  1.

Function
REQ-011 SHALL implement Moore FSM INIT_PL -> INIT_PH -> INIT_CTRL -> RUN -> ACK -> TICK -> RUN; bus outputs decoded from state only.
REQ-012 INIT_PL SHALL drive chipselect=1, write_n=0, address=2, writedata=PERIOD[15:0] for one cycle.
REQ-013 INIT_PH SHALL write address=3, writedata=PERIOD[31:16]; INIT_CTRL SHALL write address=1, writedata=16'h0007 (ITO, CONT, START).
REQ-014 Every write SHALL last exactly one cycle; no wait states; readdata not used.
REQ-015 In RUN, SHALL hold chipselect=0, write_n=1, address=0, writedata=0; SHALL move to ACK on the first edge with timer_irq=1.
REQ-016 ACK SHALL write address=0, writedata=0 (clear timeout); TICK SHALL increment time, pulse sec_tick, return to RUN.
REQ-017 timer_irq SHALL be ignored outside RUN; a level still high on RUN entry SHALL be serviced (no lost second).
REQ-018 Increment SHALL wrap ss 59->0 carrying to mm, mm 59->0 carrying to hh, hh 23->0; 23:59:59 -> 00:00:00.
REQ-019 set_valid SHALL load hh/mm/ss on the next edge in any state; if coincident with TICK, load SHALL win and no increment occurs.
REQ-020 set_valid with set_hh>23, set_mm>59 or set_ss>59 SHALL be ignored entirely; alarm_valid with out-of-range fields SHALL likewise be ignored.
REQ-021 alarm_ring SHALL set on the edge ending TICK when alarm_en=1 and new time equals alarm_hh:alarm_mm:00, and on a set_valid load equal to that time.
REQ-022 alarm_ring SHALL clear on alarm_stop=1 or alarm_en=0; clear SHALL win over a coincident set.
REQ-023 sec_tick SHALL be 1 exactly in TICK cycles, including when set_valid overrides the increment.

Reset
REQ-024 reset_n=0 SHALL force state INIT_PL, hh/mm/ss=0, alarm registers 0:00, alarm_ring=0, sec_tick=0.
REQ-025 During reset, bus SHALL read chipselect=0, write_n=1, address=0, writedata=0; first write (INIT_PL) SHALL appear in the first cycle after reset_n rises.
REQ-026 Reset asserted mid-operation SHALL abort any write immediately and restart the full init sequence.

Structure
REQ-027 Package alarm_clock_pkg SHALL hold the FSM state enum, timer register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3), control bits (ITO=0, CONT=1, START=2, STOP=3) and limits (23, 59).
REQ-028 Time-of-day counters SHALL be one sub-module tod_counter (load, inc, hh/mm/ss out); FSM and alarm compare in the top.

Verification
REQ-029 Release reset -> cycles 1..3 write (2,16'hF07F), (3,16'h02FA), (1,16'h0007), then idle bus.
REQ-030 Raise timer_irq in RUN -> next cycle write (0,16'h0000), following cycle sec_tick=1, ss 0->1; irq dropped after ACK gives no second tick.
REQ-031 set 23:59:59, one irq -> 00:00:00, single sec_tick.
REQ-032 alarm 07:30, alarm_en=1, set 07:29:59, irq -> alarm_ring=1; alarm_stop -> 0; alarm_en=0 case never rings.
REQ-033 set_valid 12:00:00 in TICK cycle -> time 12:00:00, sec_tick=1; set_hh=24 -> time unchanged.
REQ-034 Assert reset_n=0 during ACK -> bus idle immediately, time 00:00:00, init writes repeat after release.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock sequencer: FSM states,
// interval-timer register map, control bits, time limits and bus decode.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    S_INIT_PL,
    S_INIT_PH,
    S_INIT_CTRL,
    S_RUN,
    S_ACK,
    S_TICK
  } state_t;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Interrupt on timeout, continuous reload, start counting.
  localparam logic [15:0] CTRL_WORD = (16'd1 << CTRL_ITO) | (16'd1 << CTRL_CONT) |
                                      (16'd1 << CTRL_START);

  localparam logic [4:0] MAX_HH = 5'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'd0};

  function automatic logic tod_in_range(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] s);
    return (h <= MAX_HH) && (m <= MAX_MS) && (s <= MAX_MS);
  endfunction

  // Moore decode: each write state owns exactly one single-cycle bus write.
  function automatic bus_t bus_decode(input state_t s, input logic [31:0] period);
    bus_t b;
    b = BUS_IDLE;
    case (s)
      S_INIT_PL:   b = '{cs: 1'b1, write_n: 1'b0, addr: REG_PERIODL, data: period[15:0]};
      S_INIT_PH:   b = '{cs: 1'b1, write_n: 1'b0, addr: REG_PERIODH, data: period[31:16]};
      S_INIT_CTRL: b = '{cs: 1'b1, write_n: 1'b0, addr: REG_CONTROL, data: CTRL_WORD};
      S_ACK:       b = '{cs: 1'b1, write_n: 1'b0, addr: REG_STATUS,  data: 16'd0};
      default:     b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tod_counter.sv
// Time-of-day register with synchronous load and one-second increment.
// nxt_* exposes the value being registered so the top can compare it.
module tod_counter
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       inc,
  input  logic [4:0] ld_hh,
  input  logic [5:0] ld_mm,
  input  logic [5:0] ld_ss,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic [4:0] nxt_hh,
  output logic [5:0] nxt_mm,
  output logic [5:0] nxt_ss
);

  // Load takes priority over increment.
  always_comb begin
    nxt_hh = hh;
    nxt_mm = mm;
    nxt_ss = ss;
    if (load) begin
      nxt_hh = ld_hh;
      nxt_mm = ld_mm;
      nxt_ss = ld_ss;
    end else if (inc) begin
      if (ss == MAX_MS) begin
        nxt_ss = 6'd0;
        if (mm == MAX_MS) begin
          nxt_mm = 6'd0;
          nxt_hh = (hh == MAX_HH) ? 5'd0 : hh + 5'd1;
        end else begin
          nxt_mm = mm + 6'd1;
        end
      end else begin
        nxt_ss = ss + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hh <= 5'd0;
      mm <= 6'd0;
      ss <= 6'd0;
    end else begin
      hh <= nxt_hh;
      mm <= nxt_mm;
      ss <= nxt_ss;
    end
  end

endmodule

// File: rtl/alarm_clock_sequencer.sv
// Programs an interval timer for a 1 s period, counts seconds off its
// interrupt, keeps time of day and raises an alarm at a programmed hh:mm.
module alarm_clock_sequencer
  import alarm_clock_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'h2FAF07F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic        timer_irq,
  input  logic        set_valid,
  input  logic [4:0]  set_hh,
  input  logic [5:0]  set_mm,
  input  logic [5:0]  set_ss,
  input  logic        alarm_valid,
  input  logic [4:0]  alarm_hh,
  input  logic [5:0]  alarm_mm,
  input  logic        alarm_en,
  input  logic        alarm_stop,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic        sec_tick,
  output logic        alarm_ring
);

  state_t     state;
  bus_t       bus;
  logic       set_ok, alarm_ok, tick_st, ring_hit;
  logic [4:0] al_hh, nxt_hh;
  logic [5:0] al_mm, nxt_mm, nxt_ss;

  assign set_ok   = set_valid && tod_in_range(set_hh, set_mm, set_ss);
  assign alarm_ok = alarm_valid && tod_in_range(alarm_hh, alarm_mm, 6'd0);
  assign tick_st  = (state == S_TICK);

  tod_counter u_tod (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (set_ok),
    .inc    (tick_st),
    .ld_hh  (set_hh),
    .ld_mm  (set_mm),
    .ld_ss  (set_ss),
    .hh     (hh),
    .mm     (mm),
    .ss     (ss),
    .nxt_hh (nxt_hh),
    .nxt_mm (nxt_mm),
    .nxt_ss (nxt_ss)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT_PL;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= (state == S_ACK);
      case (state)
        S_INIT_PL:   state <= S_INIT_PH;
        S_INIT_PH:   state <= S_INIT_CTRL;
        S_INIT_CTRL: state <= S_RUN;
        S_RUN:       if (timer_irq) state <= S_ACK;
        S_ACK:       state <= S_TICK;
        S_TICK:      state <= S_RUN;
        default:     state <= S_INIT_PL;
      endcase
    end
  end

  // Bus is forced idle while reset is held so an in-flight write aborts at once.
  always_comb begin
    bus = BUS_IDLE;
    if (reset_n) bus = bus_decode(state, PERIOD);
  end

  assign avm_chipselect = bus.cs;
  assign avm_write_n    = bus.write_n;
  assign avm_address    = bus.addr;
  assign avm_writedata  = bus.data;

  assign ring_hit = alarm_en && (set_ok || tick_st) &&
                    (nxt_hh == al_hh) && (nxt_mm == al_mm) && (nxt_ss == 6'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      al_hh      <= 5'd0;
      al_mm      <= 6'd0;
      alarm_ring <= 1'b0;
    end else begin
      if (alarm_ok) begin
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
      end
      if (alarm_stop || !alarm_en) alarm_ring <= 1'b0;
      else if (ring_hit)           alarm_ring <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_clock_sequencer.sv
// Scoreboard bench: stimulus queues expected bus writes and post-tick times,
// a negedge monitor pops and compares whenever the DUT writes or ticks.
module tb_alarm_clock_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic        timer_irq = 1'b0;
  logic        set_valid = 1'b0;
  logic [4:0]  set_hh = '0;
  logic [5:0]  set_mm = '0, set_ss = '0;
  logic        alarm_valid = 1'b0;
  logic [4:0]  alarm_hh = '0;
  logic [5:0]  alarm_mm = '0;
  logic        alarm_en = 1'b0, alarm_stop = 1'b0;
  logic [4:0]  hh;
  logic [5:0]  mm, ss;
  logic        sec_tick, alarm_ring;

  alarm_clock_sequencer #(.PERIOD(32'h2FAF07F)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .timer_irq(timer_irq),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_valid(alarm_valid), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_en(alarm_en), .alarm_stop(alarm_stop),
    .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [4:0] h; logic [5:0] m; logic [5:0] s; logic r; } tk_t;

  localparam logic [31:0] IDLE_VEC = {11'd0, 1'b0, 1'b1, 3'd0, 16'd0};

  wr_t wq[$];
  tk_t tq[$];
  int  n_cmp = 0, n_bad = 0;
  bit  tick_pend = 1'b0;

  function automatic logic [31:0] bus_vec();
    return {11'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata};
  endfunction

  function automatic logic [31:0] time_vec();
    return {15'd0, hh, mm, ss};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a write is checked in the cycle it is presented, a tick's
  // resulting time and ring state one cycle later.
  always @(negedge clk) begin
    wr_t w;
    tk_t t;
    if (tick_pend) begin
      tick_pend = 1'b0;
      if (tq.size() == 0) chk("tick_unexpected", 32'd1, 32'd0);
      else begin
        t = tq.pop_front();
        chk("tick_time_ring", {14'd0, hh, mm, ss, alarm_ring}, {14'd0, t});
      end
    end
    if (avm_chipselect || !avm_write_n) begin
      if (wq.size() == 0) chk("bus_unexpected", bus_vec(), IDLE_VEC);
      else begin
        w = wq.pop_front();
        chk("bus_write", bus_vec(), {11'd0, 1'b1, 1'b0, w.a, w.d});
      end
    end
    if (sec_tick) tick_pend = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    wq.push_back('{a: 3'd2, d: 16'hF07F});
    wq.push_back('{a: 3'd3, d: 16'h02FA});
    wq.push_back('{a: 3'd1, d: 16'h0007});
  endtask

  task automatic expect_tick(input logic [4:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic r);
    wq.push_back('{a: 3'd0, d: 16'h0000});
    tq.push_back('{h: h, m: m, s: s, r: r});
  endtask

  task automatic pulse_irq();
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    repeat (4) step();
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
  endtask

  task automatic set_alarm(input logic [4:0] h, input logic [5:0] m);
    alarm_hh = h; alarm_mm = m; alarm_valid = 1'b1;
    step();
    alarm_valid = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", bus_vec(), IDLE_VEC);
    chk("reset_time", time_vec(), 32'd0);
    chk("reset_tick_ring", {30'd0, sec_tick, alarm_ring}, 32'd0);

    push_init();
    step();
    reset_n = 1'b1;
    repeat (5) step();

    // Basic second: 00:00:00 -> 00:00:01, irq dropped after ACK.
    expect_tick(5'd0, 6'd1, 6'd0, 1'b0);
    tq.pop_back();
    tq.push_back('{h: 5'd0, m: 6'd0, s: 6'd1, r: 1'b0});
    pulse_irq();

    // Midnight wrap.
    set_time(5'd23, 6'd59, 6'd59);
    expect_tick(5'd0, 6'd0, 6'd0, 1'b0);
    pulse_irq();

    // Alarm at 07:30 rings on the tick into 07:30:00, then stop silences it.
    set_alarm(5'd7, 6'd30);
    alarm_en = 1'b1;
    set_time(5'd7, 6'd29, 6'd59);
    expect_tick(5'd7, 6'd30, 6'd0, 1'b1);
    pulse_irq();
    alarm_stop = 1'b1;
    step();
    alarm_stop = 1'b0;
    @(negedge clk);
    chk("ring_after_stop", {31'd0, alarm_ring}, 32'd0);

    // Out-of-range alarm load is ignored; 07:30 still rings, alarm_en=0 clears.
    set_alarm(5'd7, 6'd60);
    set_time(5'd7, 6'd29, 6'd59);
    expect_tick(5'd7, 6'd30, 6'd0, 1'b1);
    pulse_irq();
    alarm_en = 1'b0;
    step();
    @(negedge clk);
    chk("ring_after_disable", {31'd0, alarm_ring}, 32'd0);

    // Disarmed: same crossing never rings.
    set_time(5'd7, 6'd29, 6'd59);
    expect_tick(5'd7, 6'd30, 6'd0, 1'b0);
    pulse_irq();

    // Load coincident with TICK wins over the increment; tick still pulses.
    expect_tick(5'd12, 6'd0, 6'd0, 1'b0);
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    step();
    set_hh = 5'd12; set_mm = 6'd0; set_ss = 6'd0; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    repeat (3) step();

    // Out-of-range set is ignored.
    set_time(5'd24, 6'd0, 6'd0);
    @(negedge clk);
    chk("bad_set_ignored", time_vec(), {15'd0, 5'd12, 6'd0, 6'd0});

    // Reset during ACK aborts the write and restarts init.
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_bus", bus_vec(), IDLE_VEC);
    chk("midrst_time", time_vec(), 32'd0);
    push_init();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();

    // Level held across TICK into RUN is serviced again.
    expect_tick(5'd0, 6'd0, 6'd1, 1'b0);
    expect_tick(5'd0, 6'd0, 6'd2, 1'b0);
    timer_irq = 1'b1;
    repeat (4) step();
    timer_irq = 1'b0;
    repeat (6) step();

    @(negedge clk);
    chk("writes_left", wq.size(), 32'd0);
    chk("ticks_left", tq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
